// File: rtl/sauber_io_dr_codec.sv
// Dual-rail pad codec: PAD_I -> precharge/evaluate A_Q0 pair; A_I0/A_T -> PAD_O/PAD_T with violation tracking.
// Latency PAD_I->A_Q0 SYNC_STAGES+1..+period+1 cycles, RX decode 1 cycle; free-running phases, no backpressure.
module sauber_io_dr_codec #(
  parameter int SYNC_STAGES    = 2,
  parameter int PRE_CYCLES     = 1,
  parameter int EVAL_CYCLES    = 1,
  parameter int ERR_CNT_W      = 8,
  parameter bit FAULT_TRISTATE = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic                 PAD_I,
  output logic                 A_Q0_t,
  output logic                 A_Q0_f,
  input  logic                 A_I0_t,
  input  logic                 A_I0_f,
  input  logic                 A_T,
  output logic                 PAD_O,
  output logic                 PAD_T,
  output logic                 phase_eval,
  input  logic                 clear_fault,
  output logic                 fault,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int MAX_CYC = (PRE_CYCLES > EVAL_CYCLES) ? PRE_CYCLES : EVAL_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {PRE = 1'b0, EVAL = 1'b1} phase_t;

  phase_t                 state;
  phase_t                 nxt_state;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_i;
  logic                   d;
  logic                   d_nxt;
  logic                   last;
  logic                   eval_end;
  logic                   pre_end;
  logic                   code_ok;
  logic                   viol;
  logic                   pad_t_q;

  assign sync_i = sync_q[SYNC_STAGES-1];

  always_comb begin
    last      = (cnt == CW'(1));
    nxt_state = state;
    if (last) nxt_state = (state == PRE) ? EVAL : PRE;
    eval_end  = (state == EVAL) && last;
    pre_end   = (state == PRE) && last;
    d_nxt     = pre_end ? sync_i : d;
    code_ok   = A_I0_t ^ A_I0_f;
    viol      = (eval_end && !code_ok) || (pre_end && (A_I0_t || A_I0_f));
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], PAD_I};
    end
  end

  // Rails are computed from the next phase so the codeword lines up with phase_eval.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= PRE;
      cnt        <= CW'(PRE_CYCLES);
      d          <= 1'b0;
      A_Q0_t     <= 1'b0;
      A_Q0_f     <= 1'b0;
      phase_eval <= 1'b0;
    end else begin
      state      <= nxt_state;
      d          <= d_nxt;
      A_Q0_t     <= (nxt_state == EVAL) & d_nxt;
      A_Q0_f     <= (nxt_state == EVAL) & ~d_nxt;
      phase_eval <= (nxt_state == EVAL);
      if (last) cnt <= (state == PRE) ? CW'(EVAL_CYCLES) : CW'(PRE_CYCLES);
      else      cnt <= cnt - CW'(1);
    end
  end

  // A violation on the same edge as clear_fault restarts the count at one.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      PAD_O     <= 1'b0;
      pad_t_q   <= 1'b1;
      fault     <= 1'b0;
      err_count <= '0;
    end else begin
      if (eval_end && code_ok) begin
        PAD_O   <= A_I0_t;
        pad_t_q <= A_T;
      end
      if (viol) begin
        fault <= 1'b1;
        if (clear_fault)           err_count <= ERR_CNT_W'(1);
        else if (err_count != '1)  err_count <= err_count + ERR_CNT_W'(1);
      end else if (clear_fault) begin
        fault     <= 1'b0;
        err_count <= '0;
      end
    end
  end

  assign PAD_T = pad_t_q | (FAULT_TRISTATE & fault);

endmodule

// File: doc/sauber_io_dr_codec.md
# sauber_io_dr_codec

Pad-side dual-rail codec for SAUBER I/O tiles: the pad-facing counterpart of the ctrl_IO switch matrix. Converts the single-rail pad input into the precharge/evaluate dual-rail pair the fabric consumes (A_Q0_t/A_Q0_f). Checks and decodes the dual-rail pair the fabric drives toward the pad (A_I0_t/A_I0_f, A_T) into single-rail PAD_O/PAD_T. Counts protocol violations and raises a sticky fault.

## Interface
- SYNC_STAGES, 2, synchronizer flops on PAD_I (legal range 2..4)
- PRE_CYCLES, 1, cycles per precharge (spacer) phase (≥1)
- EVAL_CYCLES, 1, cycles per evaluate phase (≥1)
- ERR_CNT_W, 8, width of saturating error counter
- FAULT_TRISTATE, 1, when 1 a set fault forces PAD_T=1

Ports:
- CLK  in  1  tile clock; all state on rising edge
- RESET_N  in  1  asynchronous active-low reset
- PAD_I  in  1  asynchronous pad input
- A_Q0_t, A_Q0_f  out  1 each  dual-rail pad value to the fabric
- A_I0_t, A_I0_f  in  1 each  dual-rail output value from the fabric
- A_T  in  1  output-enable from the fabric (1 = high-Z)
- PAD_O  out  1  decoded pad output
- PAD_T  out  1  pad tristate control (1 = high-Z)
- phase_eval  out  1  1 during evaluate phase
- clear_fault  in  1  synchronous pulse; clears fault and err_count
- fault  out  1  sticky protocol-violation flag
- err_count  out  ERR_CNT_W  saturating violation count

## Operation
- Phase FSM has two states, PRE and EVAL.
  - PRE lasts PRE_CYCLES cycles, then moves to EVAL.
  - EVAL lasts EVAL_CYCLES cycles, then moves to PRE.
  - A single phase counter is reloaded at each transition.
- TX (pad to fabric):
  - PAD_I passes through SYNC_STAGES flops, giving sync_i.
  - sync_i is captured into d on the PRE→EVAL transition edge.
  - In EVAL: A_Q0_t = d, A_Q0_f = ~d.
  - In PRE: both rails are 0 (spacer).
  - A_Q0 rails are registered outputs and never both 1.
- RX (fabric to pad), checked on the final cycle of each phase:
  - End of EVAL, A_I0 pair {t,f}:
    - 10: PAD_O←1, PAD_T←A_T.
    - 01: PAD_O←0, PAD_T←A_T.
    - 00 (incomplete) or 11 (invalid): violation; PAD_O and PAD_T hold.
  - End of PRE: any rail at 1 is a spacer violation; PAD_O and PAD_T hold.
- Violation bookkeeping:
  - Each violation sets fault and increments err_count.
  - err_count saturates at 2^ERR_CNT_W−1.
- Fault forcing: when fault=1 and FAULT_TRISTATE=1, PAD_T is forced to 1 regardless of A_T. PAD_O still updates on valid codewords.
- clear_fault:
  - Sets fault←0 and err_count←0 on the next edge.
  - If a violation is detected on the same edge, the violation wins: fault=1, err_count=1.
- Reset values (asynchronous, while RESET_N=0):
  - FSM=PRE with counter at PRE_CYCLES, synchronizer flops=0, d=0.
  - A_Q0_t=A_Q0_f=0, PAD_O=0, PAD_T=1, phase_eval=0, fault=0, err_count=0.
- Reset deassertion:
  - Deassertion is assumed synchronous to CLK externally.
  - The first PRE phase after release is a full PRE_CYCLES long.
- Reset mid-EVAL drops both A_Q0 rails to 0 immediately (asynchronously). No partial codeword is ever emitted.

## Timing
- PAD_I to sync_i: SYNC_STAGES cycles.
- A_Q0 codeword appears the cycle after the PRE→EVAL edge. It stays stable for exactly EVAL_CYCLES cycles, then returns to 00.
- A PAD_I change reaches A_Q0 after SYNC_STAGES + 1 to SYNC_STAGES + PRE_CYCLES + EVAL_CYCLES + 1 cycles, depending on phase alignment.
- RX sample point is the last EVAL cycle. PAD_O/PAD_T update one cycle later, i.e. the first cycle of PRE.
- A violation makes fault/err_count visible the cycle after the offending sample.
- phase_eval is registered and aligned with the A_Q0 evaluate window.
- Period = PRE_CYCLES + EVAL_CYCLES cycles, 2 with defaults.

## Test plan
- Reset and idle:
  - Stimulus: hold RESET_N=0, then release with PAD_I=0 and A_I0 driven correctly.
  - Required: A_Q0=00, PAD_T=1, PAD_O=0 in reset. After release, A_Q0 alternates 00/01 with period 2 and fault stays 0.
- TX latency:
  - Stimulus: defaults; PAD_I 0→1 at cycle 0.
  - Required: A_Q0=10 in an EVAL cycle no earlier than cycle 3 and no later than cycle 5. A_Q0=00 in every PRE cycle.
- RX decode:
  - Stimulus: drive A_I0=10 with A_T=0 in EVAL.
  - Required: PAD_O=1, PAD_T=0 at the next cycle.
  - Stimulus: then drive 01.
  - Required: PAD_O=0.
- Violations:
  - Stimulus: drive 11 in EVAL.
    - Required: PAD_O holds, fault=1, err_count=1, PAD_T=1.
  - Stimulus: drive 10 during PRE.
    - Required: err_count=2.
  - Stimulus: drive 00 in EVAL.
    - Required: err_count=3.
- Saturation and clear:
  - Stimulus: ERR_CNT_W=2, inject 5 violations.
    - Required: err_count stops at 3.
  - Stimulus: clear_fault on the same edge as a violation.
    - Required: fault=1, err_count=1.
  - Stimulus: clear_fault alone.
    - Required: fault=0, err_count=0.
- Asynchronous reset mid-EVAL:
  - Stimulus: assert RESET_N=0 between edges while A_Q0=10.
  - Required: A_Q0=00 and PAD_T=1 immediately, without waiting for an edge.
